gpio_pad_cond: RTL and testbench
================================

GPIO_PAD_COND -- requirements
Module: gpio_pad_cond

Interface
REQ-001 Parameter NCH, default 32: number of GPIO channels, legal 1..32.
REQ-002 Parameter DB_W, default 16: debounce counter and db_limit width, legal 4..24.
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal 2..4.
REQ-004 Parameter IVAL_RST, default all-zero (NCH bits): reset value of the conditioned inputs.
REQ-005 clk  in  1  single block clock; all flops on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset; one clock, asynchronous active-low reset.
REQ-007 db_limit  in  DB_W  debounce threshold in cycles; 0 is treated as 1.
REQ-008 db_en  in  NCH  per-channel debounce enable.
REQ-009 od_en  in  NCH  per-channel open-drain mode (I2C-style pins).
REQ-010 core_oval  in  NCH  output value from the SoC GPIO controller.
REQ-011 core_oe  in  NCH  output enable from the SoC GPIO controller.
REQ-012 pad_ival  in  NCH  raw, asynchronous pad input from the IO buffer.
REQ-013 pad_oval  out  NCH  data to the IO buffer driver.
REQ-014 pad_t  out  NCH  IO buffer tristate control; 1 = high-Z.
REQ-015 core_ival  out  NCH  synchronized and debounced input to the SoC.
REQ-016 rise_evt  out  NCH  one-cycle pulse on a 0->1 change of core_ival.
REQ-017 fall_evt  out  NCH  one-cycle pulse on a 1->0 change of core_ival.

Function
REQ-018 Push-pull (od_en=0): pad_oval and pad_t shall be registered as core_oval and ~core_oe; latency is 1 cycle.
REQ-019 Open-drain (od_en=1): pad_oval shall be registered as 0 and pad_t as ~(core_oe & ~core_oval), so the pin is only driven low; latency is 1 cycle.
REQ-020 A change of od_en shall take effect on pad outputs at the next edge, with no intermediate driven-high cycle in open-drain mode.
REQ-021 pad_ival shall pass through a SYNC_STAGES flop chain per channel; no logic shall sit between the chain stages.
REQ-022 Bypass (db_en=0): core_ival shall equal the synchronizer output delayed one flop, giving a total of SYNC_STAGES+1 edges from a pad change.
REQ-023 Debounce (db_en=1): the per-channel counter shall clear on any cycle where the sync output equals core_ival, and increment otherwise.
REQ-024 core_ival shall toggle on the L-th consecutive edge at which the sync output differs from core_ival, where L = max(db_limit, 1); the counter then clears.
REQ-025 A glitch shorter than L cycles shall never change core_ival.
REQ-026 With L=1, debounce shall be cycle-identical to bypass.
REQ-027 The counter shall never wrap; at db_limit = 2^DB_W-1 the toggle occurs exactly at that count.
REQ-028 Deasserting db_en shall clear that channel's counter the same cycle; asserting it shall start counting from 0.
REQ-029 If db_limit changes while counting, the comparison shall use the new value; if the count is already at or above the new L, the channel toggles at the next differing edge.
REQ-030 rise_evt and fall_evt shall be registered and asserted in exactly the first cycle core_ival shows its new value; they are mutually exclusive per channel.
REQ-031 Channels shall be fully independent; simultaneous changes on all NCH channels shall all be processed in the same cycles.

Reset
REQ-032 While rst_n=0, all of the following shall hold asynchronously: pad_t all 1; pad_oval all 0; sync flops, core_ival and internal previous-value state = IVAL_RST; counters 0; rise_evt and fall_evt 0.
REQ-033 No event shall fire as a consequence of reset deassertion alone.
REQ-034 Reset asserted mid-debounce shall abort the count with no event.

Structure
REQ-035 Package gpio_pad_pkg shall hold the default parameter constants and the sync-depth and counter-width limits.
REQ-036 Per-channel logic shall be sub-module gpio_pad_chan (synchronizer, debounce counter, edge detect, pad register), instantiated NCH times with generate.

Verification
REQ-037 Reset, then core_oe=1, core_oval=1, od_en=0 -> pad_oval=1 and pad_t=0 after 1 edge; with od_en=1 -> pad_oval=0 and pad_t=1.
REQ-038 db_en=0, pad 0->1 -> core_ival=1 and a one-cycle rise_evt at edge 3 (SYNC_STAGES=2).
REQ-039 db_en=1, db_limit=10, pad high for 9 cycles then low -> no change, no event; pad high for 10 cycles -> toggle at edge 2+10=12 with one rise_evt.
REQ-040 db_limit=0 versus db_en=0 on two channels with identical stimulus -> identical core_ival and event traces.
REQ-041 rst_n pulsed low at counter=5 of 10 -> outputs return to reset values, no event after release, and counting restarts from 0.
REQ-042 Random pad toggling on 32 channels with random db_en/od_en -> matches the reference model cycle for cycle, and rise_evt and fall_evt are never both high.

Source files
------------

// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg
// Shared constants for the GPIO pad conditioning block: default parameter
// values, legal ranges for the synchronizer depth and debounce counter width,
// and the pad drive mode encoding used by the per-channel logic.
// No ports; imported by gpio_pad_chan and gpio_pad_cond.
package gpio_pad_pkg;

   localparam int GPIO_NCH_DEFAULT  = 32;
   localparam int GPIO_NCH_MIN      = 1;
   localparam int GPIO_NCH_MAX      = 32;

   localparam int GPIO_DB_W_DEFAULT = 16;
   localparam int GPIO_DB_W_MIN     = 4;
   localparam int GPIO_DB_W_MAX     = 24;

   localparam int GPIO_SYNC_DEFAULT = 2;
   localparam int GPIO_SYNC_MIN     = 2;
   localparam int GPIO_SYNC_MAX     = 4;

   // Pad drive style selected by od_en.
   typedef enum logic {
      PAD_PUSH_PULL  = 1'b0,
      PAD_OPEN_DRAIN = 1'b1
   } pad_mode_e;

endpackage

// File: rtl/gpio_pad_chan.sv
// gpio_pad_chan
// One GPIO channel: output pad register (push-pull or open-drain), input
// synchronizer chain, optional debounce counter and rise/fall event flags.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   db_limit [DB_W]       debounce threshold in cycles (0 behaves as 1)
//   db_en                 debounce enable for this channel
//   od_en                 open-drain mode for this channel
//   core_oval, core_oe    output value / enable from the GPIO controller
//   pad_ival              raw asynchronous pad input
//   pad_oval, pad_t       IO buffer data and tristate (1 = high-Z)
//   core_ival             conditioned input to the SoC
//   rise_evt, fall_evt    one-cycle pulses on a change of core_ival
module gpio_pad_chan
   import gpio_pad_pkg::*;
#(
   parameter int   DB_W        = GPIO_DB_W_DEFAULT,
   parameter int   SYNC_STAGES = GPIO_SYNC_DEFAULT,
   parameter logic IVAL_RST    = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DB_W-1:0] db_limit,
   input  logic            db_en,
   input  logic            od_en,
   input  logic            core_oval,
   input  logic            core_oe,
   input  logic            pad_ival,
   output logic            pad_oval,
   output logic            pad_t,
   output logic            core_ival,
   output logic            rise_evt,
   output logic            fall_evt
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   core_ival_q, core_ival_d;
   logic [DB_W-1:0]        cnt_q, cnt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   pad_oval_q, pad_oval_d;
   logic                   pad_t_q, pad_t_d;

   logic                   sync_out;
   logic [DB_W-1:0]        lim_eff;
   logic [DB_W:0]          cnt_inc;
   logic                   reached;
   pad_mode_e              mode;

   // Input path: a plain shift chain into the synchronizer, then either a
   // straight one-flop copy (bypass) or a run-length debounce. The counter
   // holds the number of consecutive differing edges seen so far; the edge
   // that would bring it to L toggles the output instead, so the counter
   // never climbs past L-1 and cannot wrap even at the largest limit. The
   // extra top bit in cnt_inc keeps that comparison exact at 2^DB_W-1, and
   // the >= also covers a limit lowered below a count already in progress.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], pad_ival};
      sync_out    = sync_q[SYNC_STAGES-1];
      lim_eff     = (db_limit == '0) ? DB_W'(1) : db_limit;
      cnt_inc     = {1'b0, cnt_q} + (DB_W+1)'(1);
      reached     = (cnt_inc >= {1'b0, lim_eff});
      cnt_d       = '0;
      core_ival_d = core_ival_q;
      if (!db_en) begin
         core_ival_d = sync_out;
      end else if (sync_out != core_ival_q) begin
         if (reached) begin
            core_ival_d = ~core_ival_q;
         end else begin
            cnt_d = cnt_inc[DB_W-1:0];
         end
      end
      // Events are registered alongside core_ival so they line up with the
      // first cycle the new value is visible.
      rise_d = core_ival_d & ~core_ival_q;
      fall_d = ~core_ival_d & core_ival_q;
   end

   // Output path: open-drain never drives a 1, it only releases the pin, so
   // switching modes cannot produce a driven-high cycle.
   always_comb begin
      mode = pad_mode_e'(od_en);
      pad_oval_d = core_oval;
      pad_t_d    = ~core_oe;
      if (mode == PAD_OPEN_DRAIN) begin
         pad_oval_d = 1'b0;
         pad_t_d    = ~(core_oe & ~core_oval);
      end
   end

   // Reset puts the pin in high-Z and loads the configured idle level into
   // the whole input path, so releasing reset cannot raise an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= {SYNC_STAGES{IVAL_RST}};
         core_ival_q <= IVAL_RST;
         cnt_q       <= '0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         pad_oval_q  <= 1'b0;
         pad_t_q     <= 1'b1;
      end else begin
         sync_q      <= sync_d;
         core_ival_q <= core_ival_d;
         cnt_q       <= cnt_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         pad_oval_q  <= pad_oval_d;
         pad_t_q     <= pad_t_d;
      end
   end

   assign pad_oval  = pad_oval_q;
   assign pad_t     = pad_t_q;
   assign core_ival = core_ival_q;
   assign rise_evt  = rise_q;
   assign fall_evt  = fall_q;

endmodule

// File: rtl/gpio_pad_cond.sv
// gpio_pad_cond
// GPIO pad conditioning for NCH independent channels: registers the pad
// drive (push-pull or open-drain) and synchronizes, optionally debounces and
// edge-detects the pad inputs before they reach the SoC.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   db_limit [DB_W]       shared debounce threshold (0 behaves as 1)
//   db_en, od_en [NCH]    per-channel debounce enable / open-drain mode
//   core_oval, core_oe    per-channel output value / enable from the SoC
//   pad_ival [NCH]        raw asynchronous pad inputs
//   pad_oval, pad_t       IO buffer data and tristate (1 = high-Z)
//   core_ival [NCH]       conditioned inputs
//   rise_evt, fall_evt    per-channel one-cycle change pulses
module gpio_pad_cond
   import gpio_pad_pkg::*;
#(
   parameter int             NCH         = GPIO_NCH_DEFAULT,
   parameter int             DB_W        = GPIO_DB_W_DEFAULT,
   parameter int             SYNC_STAGES = GPIO_SYNC_DEFAULT,
   parameter logic [NCH-1:0] IVAL_RST    = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [DB_W-1:0] db_limit,
   input  logic [NCH-1:0]  db_en,
   input  logic [NCH-1:0]  od_en,
   input  logic [NCH-1:0]  core_oval,
   input  logic [NCH-1:0]  core_oe,
   input  logic [NCH-1:0]  pad_ival,
   output logic [NCH-1:0]  pad_oval,
   output logic [NCH-1:0]  pad_t,
   output logic [NCH-1:0]  core_ival,
   output logic [NCH-1:0]  rise_evt,
   output logic [NCH-1:0]  fall_evt
);

   // Channels share only clock, reset and the debounce threshold.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      gpio_pad_chan #(
         .DB_W        (DB_W),
         .SYNC_STAGES (SYNC_STAGES),
         .IVAL_RST    (IVAL_RST[i])
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .db_limit  (db_limit),
         .db_en     (db_en[i]),
         .od_en     (od_en[i]),
         .core_oval (core_oval[i]),
         .core_oe   (core_oe[i]),
         .pad_ival  (pad_ival[i]),
         .pad_oval  (pad_oval[i]),
         .pad_t     (pad_t[i]),
         .core_ival (core_ival[i]),
         .rise_evt  (rise_evt[i]),
         .fall_evt  (fall_evt[i])
      );
   end

endmodule

// File: tb/tb_gpio_pad_cond.sv
// tb_gpio_pad_cond
// Self-checking bench for gpio_pad_cond: directed scenarios followed by
// random pad/control activity, all compared every cycle against a
// run-length reference model of the conditioning rules.
module tb_gpio_pad_cond;

   localparam int          NCH  = 32;
   localparam int          DB_W = 8;
   localparam int          SS   = 2;
   localparam logic [31:0] IVAL = 32'hF000_0000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DB_W-1:0] dbLimit;
   logic [NCH-1:0]  dbEn, odEn, coreOval, coreOe, padIval;
   logic [NCH-1:0]  pad_oval, pad_t, core_ival, rise_evt, fall_evt;

   int nVec  = 0;
   int nFail = 0;

   // Reference model state.
   logic [NCH-1:0] mIval, mRise, mFall, mPadOval, mPadT;
   int             mRun [NCH];
   logic [NCH-1:0] mPadHist [$];

   always #5 clk = ~clk;

   gpio_pad_cond #(
      .NCH         (NCH),
      .DB_W        (DB_W),
      .SYNC_STAGES (SS),
      .IVAL_RST    (IVAL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .db_limit  (dbLimit),
      .db_en     (dbEn),
      .od_en     (odEn),
      .core_oval (coreOval),
      .core_oe   (coreOe),
      .pad_ival  (padIval),
      .pad_oval  (pad_oval),
      .pad_t     (pad_t),
      .core_ival (core_ival),
      .rise_evt  (rise_evt),
      .fall_evt  (fall_evt)
   );

   // Model reset: pins released, idle level everywhere, no history of change.
   task automatic modelReset();
      mIval    = IVAL;
      mRise    = '0;
      mFall    = '0;
      mPadOval = '0;
      mPadT    = '1;
      for (int c = 0; c < NCH; c++) mRun[c] = 0;
      mPadHist.delete();
      for (int k = 0; k < SS; k++) mPadHist.push_back(IVAL);
   endtask

   // One clock edge of the model: the synchronized value is the pad sample
   // from SS edges ago; debounce counts consecutive differing edges.
   task automatic modelStep();
      logic [NCH-1:0] s;
      logic           prev;
      int             lim;
      mPadHist.push_front(padIval);
      s = mPadHist[SS];
      void'(mPadHist.pop_back());
      lim = (dbLimit == 0) ? 1 : int'(dbLimit);
      for (int c = 0; c < NCH; c++) begin
         prev = mIval[c];
         if (!dbEn[c]) begin
            mIval[c] = s[c];
            mRun[c]  = 0;
         end else if (s[c] == mIval[c]) begin
            mRun[c] = 0;
         end else begin
            mRun[c]++;
            if (mRun[c] >= lim) begin
               mIval[c] = ~mIval[c];
               mRun[c]  = 0;
            end
         end
         mRise[c] = !prev && mIval[c];
         mFall[c] = prev && !mIval[c];
      end
      mPadOval = ~odEn & coreOval;
      mPadT    = (odEn & ~(coreOe & ~coreOval)) | (~odEn & ~coreOe);
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkValue("pad_oval", pad_oval, mPadOval);
      checkValue("pad_t", pad_t, mPadT);
      checkValue("core_ival", core_ival, mIval);
      checkValue("rise_evt", rise_evt, mRise);
      checkValue("fall_evt", fall_evt, mFall);
      checkValue("evt_exclusive", rise_evt & fall_evt, 32'h0);
   endtask

   // Advance n cycles; the model steps at each rising edge and outputs are
   // sampled on the following falling edge. Returns at a falling edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         modelStep();
         @(negedge clk);
         checkOutput();
      end
   endtask

   // Pulse reset between edges and check the asynchronous reset values.
   task automatic pulseReset();
      #2 rst_n = 1'b0;
      modelReset();
      #1 checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      dbLimit  = 8'd1;
      dbEn     = '0;
      odEn     = '0;
      coreOval = '0;
      coreOe   = '0;
      padIval  = IVAL;
      rst_n    = 1'b1;
      modelReset();
      #1 rst_n = 1'b0;
      #2 checkOutput();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released");

      // Push-pull drive, then open-drain on the same pin.
      coreOe[0] = 1'b1; coreOval[0] = 1'b1;
      applyStimulus(1);
      checkValue("pp_oval", {31'd0, pad_oval[0]}, 32'd1);
      checkValue("pp_t", {31'd0, pad_t[0]}, 32'd0);
      odEn[0] = 1'b1;
      applyStimulus(1);
      checkValue("od_high_oval", {31'd0, pad_oval[0]}, 32'd0);
      checkValue("od_high_t", {31'd0, pad_t[0]}, 32'd1);
      coreOval[0] = 1'b0;
      applyStimulus(1);
      checkValue("od_low_t", {31'd0, pad_t[0]}, 32'd0);

      // Bypass latency: new value and rise pulse on the third edge.
      padIval[1] = 1'b1;
      applyStimulus(2);
      checkValue("byp_edge2", {31'd0, core_ival[1]}, 32'd0);
      applyStimulus(1);
      checkValue("byp_edge3", {30'd0, core_ival[1], rise_evt[1]}, 32'd3);
      applyStimulus(1);
      checkValue("byp_edge4", {30'd0, core_ival[1], rise_evt[1]}, 32'd2);

      // Debounce L=10: 9-cycle pulse rejected, 10-cycle level accepted.
      dbEn[2] = 1'b1; dbLimit = 8'd10; padIval[2] = 1'b1;
      applyStimulus(9);
      padIval[2] = 1'b0;
      applyStimulus(15);
      checkValue("db_glitch", {31'd0, core_ival[2]}, 32'd0);
      padIval[2] = 1'b1;
      applyStimulus(11);
      checkValue("db_edge11", {30'd0, core_ival[2], rise_evt[2]}, 32'd0);
      applyStimulus(1);
      checkValue("db_edge12", {30'd0, core_ival[2], rise_evt[2]}, 32'd3);

      // Limit 0 on a debounced channel versus a bypass channel.
      dbLimit = 8'd0; dbEn[3] = 1'b1; dbEn[5] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         padIval[3] = 1'($urandom_range(0, 1));
         padIval[5] = padIval[3];
         applyStimulus(1);
      end

      // Reset in the middle of a count, then a fresh count from zero.
      dbLimit = 8'd10; dbEn[6] = 1'b1; padIval[6] = 1'b1;
      applyStimulus(7);
      pulseReset();
      applyStimulus(11);
      checkValue("rst_restart11", {30'd0, core_ival[6], rise_evt[6]}, 32'd0);
      applyStimulus(1);
      checkValue("rst_restart12", {30'd0, core_ival[6], rise_evt[6]}, 32'd3);

      // Lowering the limit below a count in progress toggles next edge.
      dbLimit = 8'd20; dbEn[8] = 1'b1; padIval[8] = 1'b1;
      applyStimulus(10);
      dbLimit = 8'd5;
      applyStimulus(1);
      checkValue("lim_drop", {30'd0, core_ival[8], rise_evt[8]}, 32'd3);

      // Largest limit: toggle exactly at count 255.
      dbLimit = 8'd255; dbEn[9] = 1'b1; padIval[9] = 1'b1;
      applyStimulus(256);
      checkValue("lim_max256", {31'd0, core_ival[9]}, 32'd0);
      applyStimulus(1);
      checkValue("lim_max257", {30'd0, core_ival[9], rise_evt[9]}, 32'd3);

      // Toggling db_en mid-count.
      dbLimit = 8'd10; dbEn[10] = 1'b1; padIval[10] = 1'b1;
      applyStimulus(6);
      dbEn[10] = 1'b0;
      applyStimulus(1);
      dbEn[10] = 1'b1; padIval[10] = 1'b0;
      applyStimulus(14);

      // Random activity on all channels.
      $display("[TB] random phase");
      for (int k = 0; k < 1500; k++) begin
         if (k % 50 == 0) begin
            dbEn    = $urandom;
            odEn    = $urandom;
            dbLimit = DB_W'($urandom_range(0, 6));
         end
         coreOval = $urandom;
         coreOe   = $urandom;
         padIval  = padIval ^ ($urandom & $urandom & $urandom);
         if (k == 777) begin
            pulseReset();
         end
         applyStimulus(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
